// File: rtl/thinpad_pkg.sv
`default_nettype none
// ============================================================================
// thinpad_pkg : shared forwarding-select codes and SRAM access FSM states
// Revision    : 1.0
// ============================================================================
package thinpad_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    WR_SETUP = 3'd2,
    WR_PULSE = 3'd3,
    WR_HOLD  = 3'd4
  } sram_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// ============================================================================
// mem_wb_stage_if : EX-side inputs, forwarding/stall outputs and SRAM bus
// Revision        : 1.0
// ============================================================================
interface mem_wb_stage_if #(
  parameter int ADDR_W = 18,
  parameter int REG_W  = 4
);
  logic [15:0]       ALURes;
  logic [15:0]       WData;
  logic              MemRead;
  logic              MemWrite;
  logic              RegWrite;
  logic [REG_W-1:0]  WReg;
  logic [REG_W-1:0]  ExRs;
  logic [REG_W-1:0]  ExRt;
  logic              ExUsesRs;
  logic              ExUsesRtAlu;
  logic              ExStoresRt;
  logic [15:0]       ALUBack;
  logic [15:0]       WriteBackData;
  logic              WbRegWrite;
  logic [REG_W-1:0]  WbReg;
  logic [1:0]        ForwardingA;
  logic [1:0]        ForwardingB;
  logic [1:0]        Forward;
  logic              Stall;
  logic [ADDR_W-1:0] RamAddr;
  logic [15:0]       RamDataOut;
  logic              RamDataOE;
  logic [15:0]       RamDataIn;
  logic              RamCE_n;
  logic              RamOE_n;
  logic              RamWE_n;

  modport master (
    output ALURes, WData, MemRead, MemWrite, RegWrite, WReg, ExRs, ExRt,
           ExUsesRs, ExUsesRtAlu, ExStoresRt, RamDataIn,
    input  ALUBack, WriteBackData, WbRegWrite, WbReg, ForwardingA, ForwardingB,
           Forward, Stall, RamAddr, RamDataOut, RamDataOE, RamCE_n, RamOE_n, RamWE_n
  );

  modport slave (
    input  ALURes, WData, MemRead, MemWrite, RegWrite, WReg, ExRs, ExRt,
           ExUsesRs, ExUsesRtAlu, ExStoresRt, RamDataIn,
    output ALUBack, WriteBackData, WbRegWrite, WbReg, ForwardingA, ForwardingB,
           Forward, Stall, RamAddr, RamDataOut, RamDataOE, RamCE_n, RamOE_n, RamWE_n
  );
endinterface
`default_nettype wire

// File: rtl/sram_access_fsm.sv
`default_nettype none
// ============================================================================
// sram_access_fsm : async SRAM wait-state sequencer with done/busy status
// Revision        : 1.0
// ============================================================================
module sram_access_fsm
  import thinpad_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic advance,
  input  logic new_read,
  input  logic new_write,
  output logic done,
  output logic busy,
  output logic ram_ce_n,
  output logic ram_oe_n,
  output logic ram_we_n,
  output logic ram_data_oe
);

  localparam int               CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

  sram_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new EX/MEM capture always overrides the current sequence; it only
  // happens once the current entry is done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:     state_d = IDLE;
      READ:     if (cnt_q == '0) state_d = IDLE; else cnt_d = cnt_q - 1'b1;
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = CNT_INIT;
      end
      WR_PULSE: if (cnt_q == '0) state_d = WR_HOLD; else cnt_d = cnt_q - 1'b1;
      WR_HOLD:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (advance) begin
      cnt_d = CNT_INIT;
      if (new_read)       state_d = READ;
      else if (new_write) state_d = WR_SETUP;
      else                state_d = IDLE;
    end
  end

  always_comb begin
    done        = 1'b0;
    busy        = 1'b0;
    ram_ce_n    = 1'b1;
    ram_oe_n    = 1'b1;
    ram_we_n    = 1'b1;
    ram_data_oe = 1'b0;
    case (state_q)
      IDLE: done = 1'b1;
      READ: begin
        ram_ce_n = 1'b0;
        ram_oe_n = 1'b0;
        done     = (cnt_q == '0);
        busy     = (cnt_q != '0);
      end
      WR_SETUP: begin
        ram_ce_n    = 1'b0;
        ram_data_oe = 1'b1;
        busy        = 1'b1;
      end
      WR_PULSE: begin
        ram_ce_n    = 1'b0;
        ram_we_n    = 1'b0;
        ram_data_oe = 1'b1;
        busy        = 1'b1;
      end
      WR_HOLD: begin
        ram_ce_n    = 1'b0;
        ram_data_oe = 1'b1;
        done        = 1'b1;
      end
      default: done = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// mem_wb_stage : EX/MEM + MEM/WB registers, SRAM access, forwarding and stall
// Revision     : 1.0
// ============================================================================
module mem_wb_stage
  import thinpad_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int REG_W       = 4,
  parameter int WAIT_CYCLES = 1,
  parameter int ZERO_REG_EN = 0
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave bus
);

  logic [15:0]      alu_q, alu_d, wdata_q, wdata_d;
  logic             mem_read_q, mem_read_d, mem_write_q, mem_write_d;
  logic             reg_write_q, reg_write_d;
  logic [REG_W-1:0] wreg_q, wreg_d;
  logic [15:0]      wb_data_q, wb_data_d;
  logic             wb_we_q, wb_we_d;
  logic [REG_W-1:0] wb_reg_q, wb_reg_d;

  logic acc_done, acc_busy, advance, stall, load_use;
  logic mem_hit_a, mem_hit_b, mem_hit_f, wb_hit_a, wb_hit_b, wb_hit_f;

  function automatic logic reg_ok(input logic [REG_W-1:0] r);
    return (ZERO_REG_EN == 0) || (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit,
                                         input logic is_load);
    if (mem_hit && !is_load) return FWD_MEM;
    if (wb_hit)              return FWD_WB;
    return FWD_REG;
  endfunction

  always_comb begin
    mem_hit_a = reg_write_q && (wreg_q == bus.ExRs) && bus.ExUsesRs    && reg_ok(bus.ExRs);
    mem_hit_b = reg_write_q && (wreg_q == bus.ExRt) && bus.ExUsesRtAlu && reg_ok(bus.ExRt);
    mem_hit_f = reg_write_q && (wreg_q == bus.ExRt) && bus.ExStoresRt  && reg_ok(bus.ExRt);
    wb_hit_a  = wb_we_q && (wb_reg_q == bus.ExRs) && bus.ExUsesRs    && reg_ok(bus.ExRs);
    wb_hit_b  = wb_we_q && (wb_reg_q == bus.ExRt) && bus.ExUsesRtAlu && reg_ok(bus.ExRt);
    wb_hit_f  = wb_we_q && (wb_reg_q == bus.ExRt) && bus.ExStoresRt  && reg_ok(bus.ExRt);
  end

  assign load_use = mem_read_q && (mem_hit_a || mem_hit_b || mem_hit_f);
  assign stall    = acc_busy || load_use;
  assign advance  = !stall;

  sram_access_fsm #(
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .advance     (advance),
    .new_read    (bus.MemRead),
    .new_write   (bus.MemWrite),
    .done        (acc_done),
    .busy        (acc_busy),
    .ram_ce_n    (bus.RamCE_n),
    .ram_oe_n    (bus.RamOE_n),
    .ram_we_n    (bus.RamWE_n),
    .ram_data_oe (bus.RamDataOE)
  );

  // Stalled-but-done only arises from load-use: the finished load leaves
  // EX/MEM as a bubble so its data is forwarded from MEM/WB next cycle.
  always_comb begin
    alu_d       = alu_q;
    wdata_d     = wdata_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    reg_write_d = reg_write_q;
    wreg_d      = wreg_q;
    if (advance) begin
      alu_d       = bus.ALURes;
      wdata_d     = bus.WData;
      mem_read_d  = bus.MemRead;
      mem_write_d = bus.MemWrite && !bus.MemRead;
      reg_write_d = bus.RegWrite;
      wreg_d      = bus.WReg;
    end else if (acc_done) begin
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      reg_write_d = 1'b0;
    end

    wb_data_d = wb_data_q;
    wb_reg_d  = wb_reg_q;
    wb_we_d   = 1'b0;
    if (acc_done) begin
      wb_data_d = mem_read_q ? bus.RamDataIn : alu_q;
      wb_we_d   = reg_write_q;
      wb_reg_d  = wreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_q       <= '0;
      wdata_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      wreg_q      <= '0;
      wb_data_q   <= '0;
      wb_we_q     <= 1'b0;
      wb_reg_q    <= '0;
    end else begin
      alu_q       <= alu_d;
      wdata_q     <= wdata_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      reg_write_q <= reg_write_d;
      wreg_q      <= wreg_d;
      wb_data_q   <= wb_data_d;
      wb_we_q     <= wb_we_d;
      wb_reg_q    <= wb_reg_d;
    end
  end

  assign bus.ALUBack       = alu_q;
  assign bus.WriteBackData = wb_data_q;
  assign bus.WbRegWrite    = wb_we_q;
  assign bus.WbReg         = wb_reg_q;
  assign bus.ForwardingA   = fwd_sel(mem_hit_a, wb_hit_a, mem_read_q);
  assign bus.ForwardingB   = fwd_sel(mem_hit_b, wb_hit_b, mem_read_q);
  assign bus.Forward       = fwd_sel(mem_hit_f, wb_hit_f, mem_read_q);
  assign bus.Stall         = stall;
  assign bus.RamAddr       = ADDR_W'(alu_q);
  assign bus.RamDataOut    = wdata_q;

endmodule
`default_nettype wire

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory-access stage of the 16-bit ThinPad pipeline. It sits directly downstream of the execute stage.
- Holds the EX/MEM and MEM/WB pipeline registers and drives the async SRAM through a wait-state FSM.
- Produces the signals the execute stage consumes: ALUBack, WriteBackData and the selects ForwardingA, ForwardingB and Forward (00 = register/immediate, 01 = ALUBack, 10 = WriteBackData).
- Generates the pipeline Stall.

Parameters:
- ADDR_W, 18, SRAM address width; the 16-bit ALU result is zero-extended to it.
- REG_W, 4, register-index width.
- WAIT_CYCLES, 1, SRAM access cycles (≥1) for a read and for the write-enable pulse.
- ZERO_REG_EN, 0, when 1, register index 0 never matches for forwarding or hazards.

Ports:
- clk in 1: clock, rising edge.
- rst in 1: synchronous, active-high reset.
- ALURes in 16: EX result, or memory address for loads/stores.
- WData in 16: EX store data, already forwarded.
- MemRead in 1, MemWrite in 1, RegWrite in 1: EX-stage control.
- WReg in REG_W: EX-stage destination register.
- ExRs in REG_W, ExRt in REG_W: EX-stage source registers.
- ExUsesRs in 1: A operand comes from a register.
- ExUsesRtAlu in 1: B operand comes from a register (0 when the immediate is selected).
- ExStoresRt in 1: EX-stage instruction is a store of Rt.
- ALUBack out 16: EX/MEM ALU result.
- WriteBackData out 16: MEM/WB result.
- WbRegWrite out 1, WbReg out REG_W: register-file write port.
- ForwardingA out 2, ForwardingB out 2, Forward out 2: EX forwarding selects.
- Stall out 1: freeze PC, IF/ID and ID/EX.
- RamAddr out ADDR_W, RamDataOut out 16, RamDataOE out 1, RamDataIn in 16: SRAM address and data bus.
- RamCE_n out 1, RamOE_n out 1, RamWE_n out 1: SRAM controls, active-low.

Behaviour:
- Reset:
  - All registers clear; FSM goes to IDLE.
  - ALUBack=0, WriteBackData=0, WbRegWrite=0, WbReg=0, selects=00, Stall=0.
  - RamCE_n=RamOE_n=RamWE_n=1, RamDataOE=0, RamAddr=0.
  - Reset mid-access aborts at that edge; no completion is reported.
- EX/MEM register:
  - Captures the EX inputs on every edge with Stall=0.
  - On capture of a load, the FSM moves to READ; on capture of a store, it moves to WR_SETUP. The counter loads WAIT_CYCLES-1.
  - RamAddr = zero-extended ALUBack; it is valid whenever the FSM is not IDLE.
- FSM:
  - READ: CE_n=0, OE_n=0. Counts down. Done when count=0, sampling RamDataIn at that edge.
  - WR_SETUP: 1 cycle, CE_n=0, RamDataOE=1, WE_n=1.
  - WR_PULSE: WAIT_CYCLES cycles with WE_n=0.
  - WR_HOLD: 1 cycle, WE_n=1, data still driven. Done here.
  - After done, the next state is decided by the next EX/MEM capture (READ, WR_SETUP or IDLE).
  - Read latency = WAIT_CYCLES. Write latency = WAIT_CYCLES+2.
- Done and busy:
  - A non-memory entry (or bubble) is done in its first cycle.
  - busy = memory access in progress and not yet done.
- MEM/WB register:
  - On done, captures the result (RamDataIn for a load, ALUBack otherwise), WbRegWrite and WbReg.
  - When not done, captures a bubble (WbRegWrite=0).
- Match definitions (Rs side; Rt side identical with ExUsesRtAlu/ExStoresRt):
  - memMatch = EX/MEM RegWrite and EX/MEM WReg==ExRs and ExUsesRs.
  - wbMatch = WbRegWrite and WbReg==ExRs and ExUsesRs.
- Select rules:
  - ForwardingA = 01 if memMatch and the entry is not a load; else 10 if wbMatch; else 00.
  - ForwardingB uses ExRt and ExUsesRtAlu.
  - Forward uses ExRt and ExStoresRt.
  - A MEM match has priority over a WB match.
  - ExUsesRtAlu=0 forces ForwardingB=00.
- Load-use:
  - loadUse = memMatch (any of the three) while the EX/MEM entry is a load.
  - Stall = busy OR loadUse.
  - If a load completes while loadUse holds, the EX/MEM entry becomes a bubble at that edge. Its data is then in MEM/WB, so the next cycle selects 10 and Stall drops.
- A load immediately followed by an independent instruction causes no stall when WAIT_CYCLES=1.

Decomposition:
- Shared package `thinpad_pkg`:
  - Forwarding-select constants FWD_REG=00, FWD_MEM=01, FWD_WB=10.
  - SRAM FSM state enum (IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD).
- One sub-module, `sram_access_fsm`:
  - Contains the state, counter, SRAM control/OE outputs and the done/busy signals.
  - Forwarding logic and the pipeline registers stay in the top module.

Test Plan:
1. Reset → assert rst for 2 cycles mid-run → all outputs at their reset values; RamCE_n=1, Stall=0.
2. ALU forwarding: ADD writes R3 with ALURes=0x1234.
   - Next instruction reads Rs=R3 → ForwardingA=01, ALUBack=0x1234.
   - One instruction later → ForwardingA=10, WriteBackData=0x1234.
   - Same case with ExUsesRtAlu=0 and Rt=R3 → ForwardingB=00.
3. Load, WAIT_CYCLES=1, ALURes=0x0040, RamDataIn=0xBEEF, no dependency → RamAddr=0x00040; CE_n/OE_n low for 1 cycle; Stall never high; next cycle WriteBackData=0xBEEF, WbRegWrite=1.
4. Load-use: load R2, then ADD with Rs=R2 → Stall high for exactly 1 cycle; then ForwardingA=10 with WriteBackData equal to the loaded data.
5. Store, WAIT_CYCLES=2, ALURes=0x0100, WData=0x5A5A:
   - WE_n low for exactly 2 cycles.
   - RamDataOE high for 4 cycles with RamDataOut=0x5A5A.
   - Stall high for 3 cycles.
6. Reset during WR_PULSE → next cycle WE_n=1, CE_n=1, RamDataOE=0, Stall=0, FSM IDLE; no WB write.
